// File: rtl/ycbcr_block_sequencer_if.sv
// Pixel-side bus of the YCbCr block sequencer: source-buffer reads, converter
// valid and result-buffer writes.
interface ycbcr_block_sequencer_if;
    // Pure strobes, no back-pressure: each cycle with a strobe high carries
    // exactly one transfer at the address shown in that same cycle.
    logic       rd_en;
    logic [5:0] rd_addr;
    logic       conv_valid;
    logic       wr_en;
    logic [5:0] wr_addr;

    modport master (output rd_en, rd_addr, conv_valid, wr_en, wr_addr);
    modport slave  (input  rd_en, rd_addr, conv_valid, wr_en, wr_addr);
endinterface

// File: rtl/ycbcr_block_sequencer.sv
// Walks one 8x8 RGB block through a fixed-latency YCbCr converter: issues
// reads 0..63 in order, tracks results through a valid/address delay line.
module ycbcr_block_sequencer #(
    parameter int CONV_LAT = 4,
    parameter int BLK_PIX  = 64
) (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic        start,
    input  logic        hold,
    output logic        busy,
    output logic        done,
    output logic [15:0] blk_count,
    output logic [1:0]  state_dbg,
    ycbcr_block_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [5:0] LAST_ADDR = 6'(BLK_PIX - 1);
    localparam logic [6:0] ALL_PIX   = 7'(BLK_PIX);

    state_t        state_q, state_d;
    logic [5:0]    iss_cnt_q, iss_cnt_d;
    logic [6:0]    wr_cnt_q, wr_cnt_d, wr_cnt_step;
    logic [15:0]   blk_cnt_q;
    logic [1:0]    rst_sync_q;
    logic          rd_en;
    logic          cv_q;
    logic [5:0]    cv_addr_q;
    logic [CONV_LAT-1:0] vld_sr_q;
    logic [5:0]    addr_sr_q [CONV_LAT];
    logic          wr_en;

    assign wr_en       = vld_sr_q[CONV_LAT-1];
    assign wr_cnt_step = wr_cnt_q + 7'(wr_en);

    // Reset release may be asynchronous; start is only honoured once this
    // two-stage chain has filled.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    always_comb begin
        state_d   = state_q;
        iss_cnt_d = iss_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        rd_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && rst_sync_q[1]) begin
                    state_d   = ISSUE;
                    iss_cnt_d = 6'd0;
                    wr_cnt_d  = 7'd0;
                end
            end
            ISSUE: begin
                wr_cnt_d = wr_cnt_step;
                if (!hold) begin
                    rd_en     = 1'b1;
                    iss_cnt_d = iss_cnt_q + 6'd1;
                    if (iss_cnt_q == LAST_ADDR) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                wr_cnt_d = wr_cnt_step;
                if (wr_cnt_step == ALL_PIX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            iss_cnt_q <= 6'd0;
            wr_cnt_q  <= 7'd0;
            blk_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            iss_cnt_q <= iss_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            // Count becomes visible during the done cycle itself.
            if (state_q == DRAIN && state_d == DONE) begin
                blk_cnt_q <= blk_cnt_q + 16'd1;
            end
        end
    end

    // Converter input stage, then CONV_LAT stages matching the converter.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            cv_q      <= 1'b0;
            cv_addr_q <= 6'd0;
            vld_sr_q  <= '0;
            for (int j = 0; j < CONV_LAT; j++) begin
                addr_sr_q[j] <= 6'd0;
            end
        end else begin
            cv_q         <= rd_en;
            cv_addr_q    <= iss_cnt_q;
            vld_sr_q[0]  <= cv_q;
            addr_sr_q[0] <= cv_addr_q;
            for (int j = 1; j < CONV_LAT; j++) begin
                vld_sr_q[j]  <= vld_sr_q[j-1];
                addr_sr_q[j] <= addr_sr_q[j-1];
            end
        end
    end

    assign bus.rd_en      = rd_en;
    assign bus.rd_addr    = iss_cnt_q;
    assign bus.conv_valid = cv_q;
    assign bus.wr_en      = wr_en;
    assign bus.wr_addr    = addr_sr_q[CONV_LAT-1];

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign blk_count = blk_cnt_q;
    assign state_dbg = state_q;

endmodule
